// File: rtl/edge_seq_pkg.sv
// Shared types and expected-response rules for the edge-protocol stimulus driver.
// The expected model tracks what an ideal responder should present on b / module_b.
package edge_seq_pkg;

  // Upper bound for STEP_W; the queued hold field is stored zero-extended to this width.
  localparam int STEP_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  a;
    logic                  ma;
    logic [STEP_W_MAX-1:0] hold;
  } edge_cmd_t;

  typedef struct packed {
    logic exp_b;
    logic exp_mb;
    logic vb;
    logic vmb;
  } exp_t;

  function automatic exp_t exp_update(
    input logic o_a,
    input logic o_ma,
    input logic n_a,
    input logic n_ma,
    input logic exp_b,
    input logic exp_mb,
    input logic vb,
    input logic vmb
  );
    exp_t r;
    r.exp_b  = exp_b;
    r.exp_mb = exp_mb;
    r.vb     = vb;
    r.vmb    = vmb;
    if (o_a != n_a) begin
      r.exp_b = ~n_a;
      r.vb    = 1'b1;
    end
    // module_b reacts to a rising a or a falling module_a
    if ((!o_a && n_a) || (o_ma && !n_ma)) begin
      r.exp_mb = ~n_ma;
      r.vmb    = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_seq_fifo.sv
// Command queue: DEPTH-entry synchronous FIFO, registered pointers, same-cycle push/pop.
// Latency: one cycle push-to-visible; backpressure via full (writes while full are dropped).
module edge_seq_fifo
  import edge_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_vld,
  input  edge_cmd_t wr_dat,
  input  logic      rd_rdy,
  output edge_cmd_t rd_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  edge_cmd_t     mem [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en  = wr_vld && !full;
  assign rd_en  = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/edge_seq_driver.sv
// Drives drv_a/drv_ma from queued level commands, holds each for `hold` cycles, checks rsp_b/rsp_mb.
// Latency: push-to-drive 2 cycles from idle; backpressure: cmd_ready drops when the queue is full.
module edge_seq_driver
  import edge_seq_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_a,
  input  logic              cmd_ma,
  input  logic [STEP_W-1:0] cmd_hold,
  output logic              drv_a,
  output logic              drv_ma,
  input  logic              rsp_b,
  input  logic              rsp_mb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  state_t            state_q;
  state_t            state_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  edge_cmd_t         push_cmd;
  edge_cmd_t         head_cmd;
  logic [STEP_W-1:0] hold_clamped;
  logic [STEP_W-1:0] hcnt_q;
  logic [STEP_W-1:0] cur_hold_q;
  logic              cur_a_q;
  logic              cur_ma_q;
  logic              exp_b_q;
  logic              exp_mb_q;
  logic              vb_q;
  logic              vmb_q;
  exp_t              exp_nxt;
  logic              apply;
  logic              hold_last;
  logic              b_bad;
  logic              mb_bad;
  logic              mismatch;

  // A zero hold would never reach the hcnt==1 exit, so it is stored as 1.
  assign hold_clamped = (cmd_hold == '0) ? STEP_W'(1) : cmd_hold;
  assign push_cmd     = '{a: cmd_a, ma: cmd_ma, hold: STEP_W_MAX'(hold_clamped)};

  edge_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (cmd_valid),
    .wr_dat (push_cmd),
    .rd_rdy (fifo_pop),
    .rd_dat (head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign apply     = (state_q == APPLY);
  assign hold_last = (state_q == HOLD) && (hcnt_q == STEP_W'(1));
  assign busy      = (state_q != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = APPLY;
      APPLY:   state_d = HOLD;
      HOLD:    if (hcnt_q == STEP_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign exp_nxt = exp_update(drv_a, drv_ma, cur_a_q, cur_ma_q,
                              exp_b_q, exp_mb_q, vb_q, vmb_q);

  // Written as "bad unless provably equal" so an unknown response counts as a mismatch.
  always_comb begin
    b_bad  = 1'b1;
    mb_bad = 1'b1;
    if (!vb_q || (rsp_b == exp_b_q))    b_bad  = 1'b0;
    if (!vmb_q || (rsp_mb == exp_mb_q)) mb_bad = 1'b0;
    mismatch = b_bad || mb_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_a_q    <= 1'b0;
      cur_ma_q   <= 1'b0;
      cur_hold_q <= '0;
    end else if (fifo_pop) begin
      cur_a_q    <= head_cmd.a;
      cur_ma_q   <= head_cmd.ma;
      cur_hold_q <= STEP_W'(head_cmd.hold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_a    <= 1'b0;
      drv_ma   <= 1'b0;
      exp_b_q  <= 1'b0;
      exp_mb_q <= 1'b0;
      vb_q     <= 1'b0;
      vmb_q    <= 1'b0;
      hcnt_q   <= '0;
    end else if (apply) begin
      drv_a    <= cur_a_q;
      drv_ma   <= cur_ma_q;
      exp_b_q  <= exp_nxt.exp_b;
      exp_mb_q <= exp_nxt.exp_mb;
      vb_q     <= exp_nxt.vb;
      vmb_q    <= exp_nxt.vmb;
      hcnt_q   <= cur_hold_q;
    end else if (state_q == HOLD) begin
      hcnt_q   <= hcnt_q - STEP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= hold_last;
      err  <= hold_last && mismatch;
      if (hold_last && mismatch && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_edge_seq_driver.sv
// Bench for edge_seq_driver: directed scenarios plus random command streams against a per-command model.
module tb_edge_seq_driver;

  localparam int STEP_W = 8;
  localparam int DEPTH  = 4;
  localparam int ERR_W  = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_a;
  logic              cmd_ma;
  logic [STEP_W-1:0] cmd_hold;
  logic              drv_a;
  logic              drv_ma;
  logic              rsp_b;
  logic              rsp_mb;
  logic              busy;
  logic              done;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;

  edge_seq_driver #(
    .STEP_W (STEP_W),
    .DEPTH  (DEPTH),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_ma    (cmd_ma),
    .cmd_hold  (cmd_hold),
    .drv_a     (drv_a),
    .drv_ma    (drv_ma),
    .rsp_b     (rsp_b),
    .rsp_mb    (rsp_mb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder: 0 ideal, 1 b stuck 1, 2 b stuck 0, 3 both inverted, 4 both unknown.
  int   rsp_mode = 0;
  logic rb = 1'b0, rmb = 1'b0, pa = 1'b0, pma = 1'b0;

  always @(posedge clk) begin
    #1;
    if (drv_a != pa) rb = ~drv_a;
    if ((!pa && drv_a) || (pma && !drv_ma)) rmb = ~drv_ma;
    pa  = drv_a;
    pma = drv_ma;
  end

  always_comb begin
    rsp_b  = rb;
    rsp_mb = rmb;
    case (rsp_mode)
      1: rsp_b = 1'b1;
      2: rsp_b = 1'b0;
      3: begin rsp_b = ~rb; rsp_mb = ~rmb; end
      4: begin rsp_b = 1'bx; rsp_mb = 1'bx; end
      default: ;
    endcase
  end

  // Per-command reference model: levels, expected responses and their valid flags.
  typedef struct { bit a; bit ma; int h; } mcmd_t;
  mcmd_t mq[$];
  mcmd_t mc;
  bit m_a, m_ma, m_eb, m_emb, m_vb, m_vmb, m_rb, m_rmb, m_bad, m_resp_b, m_resp_mb;
  int m_errs = 0;
  int done_seen = 0;
  int err_seen = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  bit gap_en = 0;

  function automatic int sat(input int n);
    return (n > ERR_MAX) ? ERR_MAX : n;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_a = 0; m_ma = 0; m_eb = 0; m_emb = 0; m_vb = 0; m_vmb = 0;
    m_errs = 0;
    last_done_cyc = -1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && err) err_seen++;
    if (rst_n && err && !done) check_eq("err_without_done", err, 1'b0);
    if (rst_n && done) begin
      done_seen++;
      check_eq("done_has_cmd", mq.size() != 0, 1);
      if (mq.size() != 0) begin
        mc = mq.pop_front();
        if (m_a != mc.a) begin m_eb = ~mc.a; m_vb = 1; m_rb = ~mc.a; end
        if ((!m_a && mc.a) || (m_ma && !mc.ma)) begin m_emb = ~mc.ma; m_vmb = 1; m_rmb = ~mc.ma; end
        m_a = mc.a;
        m_ma = mc.ma;
        m_resp_b  = (rsp_mode == 1) ? 1'b1 : (rsp_mode == 2) ? 1'b0 : (rsp_mode == 3) ? ~m_rb : m_rb;
        m_resp_mb = (rsp_mode == 3) ? ~m_rmb : m_rmb;
        m_bad = (m_vb && (m_resp_b != m_eb)) || (m_vmb && (m_resp_mb != m_emb));
        if (m_bad) m_errs++;
        check_eq("drv_a", drv_a, m_a);
        check_eq("drv_ma", drv_ma, m_ma);
        check_eq("err_pulse", err, m_bad);
        check_eq("err_cnt", err_cnt, sat(m_errs));
        if (gap_en && last_done_cyc >= 0) check_eq("done_gap", cyc - last_done_cyc, mc.h + 2);
        last_done_cyc = cyc;
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push(input bit a, input bit ma, input int h);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_ma    = ma;
    cmd_hold  = STEP_W'(h);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_accept", n < 500, 1);
    mq.push_back('{a, ma, (h == 0) ? 1 : h});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", n < 3000, 1);
    repeat (2) @(negedge clk);
    check_eq("model_drained", mq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single command into an idle, empty driver: edges from push to new drive and to done.
  task automatic lat(input bit a, input bit ma, input int h);
    int  hc;
    int  drv_k;
    int  done_k;
    bit  ia;
    bit  ima;
    hc = (h == 0) ? 1 : h;
    ia = drv_a;
    ima = drv_ma;
    drv_k = -1;
    done_k = -1;
    check_eq("lat_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_ma = ma;
    cmd_hold = STEP_W'(h);
    mq.push_back('{a, ma, hc});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      @(posedge clk);
      #1;
      if (drv_k < 0 && (drv_a != ia || drv_ma != ima)) drv_k = k;
      if (done) done_k = k;
    end
    check_eq("lat_drive", drv_k, (a != ia || ma != ima) ? 2 : -1);
    check_eq("lat_done", done_k, hc + 2);
    @(negedge clk);
  endtask

  bit [1:0] basic_lv [5];
  int d0;
  int e0;
  int n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    basic_lv = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 1'b0;
    cmd_ma = 1'b0;
    cmd_hold = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_drv_a", drv_a, 0);
    check_eq("rst_drv_ma", drv_ma, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sequence with ideal, stuck-0 and stuck-1 b responders.
    for (int m = 0; m < 3; m++) begin
      do_reset();
      rsp_mode = (m == 0) ? 0 : (m == 1) ? 2 : 1;
      d0 = done_seen;
      e0 = err_seen;
      foreach (basic_lv[i]) push(basic_lv[i][1], basic_lv[i][0], 1);
      wait_idle();
      check_eq("basic_dones", done_seen - d0, 5);
      check_eq("basic_err_pulses", err_seen - e0, m_errs);
      check_eq("basic_err_cnt", err_cnt, (m == 0) ? 0 : (m == 1) ? 3 : 2);
    end

    // No-edge command with unknown responses, then hold clamp cases.
    do_reset();
    rsp_mode = 4;
    lat(1'b0, 1'b0, 5);
    check_eq("noedge_err_cnt", err_cnt, 0);
    rsp_mode = 0;
    lat(1'b1, 1'b0, 0);
    lat(1'b0, 1'b1, 1);
    lat(1'b0, 1'b1, 4);
    check_eq("lat_err_cnt", err_cnt, 0);

    // Backpressure: six long commands against a four-deep queue.
    do_reset();
    gap_en = 1;
    d0 = done_seen;
    for (int i = 0; i < 5; i++) push(i[0], i[1], 10);
    check_eq("ready_full", cmd_ready, 0);
    push(1'b1, 1'b1, 10);
    wait_idle();
    gap_en = 0;
    check_eq("bp_dones", done_seen - d0, 6);

    // Saturation: every command toggles a against an inverting responder.
    do_reset();
    rsp_mode = 3;
    e0 = err_seen;
    for (int i = 0; i < 5; i++) push(~i[0], 1'b0, $urandom_range(0, 2));
    wait_idle();
    check_eq("sat_err_pulses", err_seen - e0, 5);
    check_eq("sat_err_cnt", err_cnt, 3);

    // Reset in HOLD with two commands still queued.
    do_reset();
    rsp_mode = 0;
    push(1'b1, 1'b1, 20);
    push(1'b0, 1'b0, 20);
    push(1'b1, 1'b0, 20);
    n = 0;
    while (!drv_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_drv_a", drv_a, 0);
    check_eq("midrst_drv_ma", drv_ma, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check_eq("midrst_no_done", done_seen - d0, 0);
    check_eq("midrst_idle", busy, 0);

    // Random command streams with random responder behaviour.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rsp_mode = $urandom_range(0, 3);
      e0 = err_seen;
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
        push($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      check_eq("rand_err_pulses", err_seen - e0, m_errs);
      check_eq("rand_err_cnt", err_cnt, sat(m_errs));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
